// File: rtl/sync_fifo_prog_pkg.sv
// Shared constants and types for the programmable-threshold synchronous FIFO.
package sync_fifo_prog_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // Status flags; names are reused by the bench when reporting flag checks.
  typedef enum logic [2:0] {
    ST_FULL,
    ST_EMPTY,
    ST_AF,
    ST_AE,
    ST_OVF,
    ST_UDF
  } status_e;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on i_inc and wraps from DEPTH-1 to 0, so any depth works.
module fifo_wrap_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty thresholds and occupancy count.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads have one cycle of latency.
module sync_fifo_prog
  import sync_fifo_prog_pkg::*;
#(
  parameter  int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PTR_W-1:0]      w_wr_ptr;
  logic [PTR_W-1:0]      w_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Flags derive from the count register only; thresholds act with no storage.
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wr_acc),
    .o_ptr (w_wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd_acc),
    .o_ptr (w_rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented as soon as it is stored; rd_en only pops it.
  assign data_out = r_mem[w_rd_ptr];
  assign rd_valid = !w_empty;
`else
  logic [FIFO_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out <= r_mem[w_rd_ptr];
      end
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
`endif

  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= af_thresh);
  assign almostempty = (r_count <= ae_thresh);
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: depth-8 table-driven sequence plus depth-5 wrap and threshold checks.
// Build with FIFO_FWFT_EN defined to exercise the fall-through read path.
module tb_sync_fifo_prog;
  import sync_fifo_prog_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Depth-8 instance
  logic        wr8 = 1'b0, rd8 = 1'b0;
  logic [15:0] din8 = '0, dout8;
  logic [3:0]  af8 = 4'd6, ae8 = 4'd2, cnt8;
  logic        rv8, full8, empty8, afl8, ael8, ack8, ovf8, udf8;

  // Depth-5 instance
  logic        wr5 = 1'b0, rd5 = 1'b0;
  logic [15:0] din5 = '0, dout5;
  logic [2:0]  af5 = 3'd4, ae5 = 3'd1, cnt5;
  logic        rv5, full5, empty5, afl5, ael5, ack5, ovf5, udf5;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr8), .data_in(din8), .rd_en(rd8),
    .data_out(dout8), .rd_valid(rv8), .af_thresh(af8), .ae_thresh(ae8),
    .count(cnt8), .full(full8), .empty(empty8), .almostfull(afl8),
    .almostempty(ael8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr5), .data_in(din5), .rd_en(rd5),
    .data_out(dout5), .rd_valid(rv5), .af_thresh(af5), .ae_thresh(ae5),
    .count(cnt5), .full(full5), .empty(empty5), .almostfull(afl5),
    .almostempty(ael5), .wr_ack(ack5), .overflow(ovf5), .underflow(udf5)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    int          cnt;
    logic        full, empty, af, ae, ack, ovf, udf, rv;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_flag(input string tag, input status_e st, input logic act, input logic exp);
    chk($sformatf("%s %s", tag, st.name()), {31'd0, act}, {31'd0, exp});
  endtask

  task automatic add(input logic wr, input logic rd, input logic [15:0] din, input int cnt,
                     input logic full, input logic empty, input logic af, input logic ae,
                     input logic ack, input logic ovf, input logic udf, input logic rv,
                     input logic [15:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.ack = ack; v.ovf = ovf; v.udf = udf; v.rv = rv; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic cyc8(input logic wr, input logic rd, input logic [15:0] din);
    wr8 = wr; rd8 = rd; din8 = din;
    @(posedge clk);
    #1;
    wr8 = 1'b0; rd8 = 1'b0;
  endtask

  initial begin
    // Fill: af=6, ae=2
    for (int k = 1; k <= 8; k++)
      add(1, 0, 16'(k), k, k == 8, 0, k >= 6, k <= 2, 1, 0, 0, 0, 16'h0);
    add(1, 0, 16'h0009, 8, 1, 0, 1, 0, 0, 1, 0, 0, 16'h0);
    // Drain in order
    for (int k = 1; k <= 8; k++)
      add(0, 1, 16'h0, 8 - k, 0, k == 8, (8 - k) >= 6, (8 - k) <= 2, 0, 0, 0, 1, 16'(k));
    add(0, 1, 16'h0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 16'h0008);
    // Simultaneous on empty, refill, simultaneous on full
    add(1, 1, 16'h0011, 1, 0, 0, 0, 1, 1, 0, 1, 0, 16'h0008);
    for (int k = 2; k <= 8; k++)
      add(1, 0, 16'(16'h10 + k), k, k == 8, 0, k >= 6, k <= 2, 1, 0, 0, 0, 16'h0008);
    add(1, 1, 16'h0019, 7, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0011);
    for (int k = 0; k < 3; k++)
      add(0, 1, 16'h0, 6 - k, 0, 0, (6 - k) >= 6, (6 - k) <= 2, 0, 0, 0, 1, 16'(16'h12 + k));

    // Reset state
    #2;
    chk("rst count", 32'(cnt8), 32'd0);
    chk_flag("rst", ST_EMPTY, empty8, 1'b1);
    chk_flag("rst", ST_FULL, full8, 1'b0);
    chk("rst wr_ack", {31'd0, ack8}, 32'd0);
`ifndef FIFO_FWFT_EN
    chk("rst rd_valid", {31'd0, rv8}, 32'd0);
    chk("rst data_out", 32'(dout8), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      wr8 = vecs[i].wr; rd8 = vecs[i].rd; din8 = vecs[i].din;
      @(posedge clk);
      #1;
      chk({t, " count"}, 32'(cnt8), 32'(vecs[i].cnt));
      chk_flag(t, ST_FULL, full8, vecs[i].full);
      chk_flag(t, ST_EMPTY, empty8, vecs[i].empty);
      chk_flag(t, ST_AF, afl8, vecs[i].af);
      chk_flag(t, ST_AE, ael8, vecs[i].ae);
      chk_flag(t, ST_OVF, ovf8, vecs[i].ovf);
      chk_flag(t, ST_UDF, udf8, vecs[i].udf);
      chk({t, " wr_ack"}, {31'd0, ack8}, {31'd0, vecs[i].ack});
`ifndef FIFO_FWFT_EN
      chk({t, " rd_valid"}, {31'd0, rv8}, {31'd0, vecs[i].rv});
      chk({t, " data_out"}, 32'(dout8), 32'(vecs[i].dout));
`endif
    end
    wr8 = 1'b0; rd8 = 1'b0;

    // Asynchronous reset mid-burst at count 4
    chk("pre-rst count", 32'(cnt8), 32'd4);
    wr8 = 1'b1; din8 = 16'h0055;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async count", 32'(cnt8), 32'd0);
    chk_flag("async", ST_EMPTY, empty8, 1'b1);
    chk_flag("async", ST_FULL, full8, 1'b0);
    chk_flag("async", ST_AF, afl8, 1'b0);
    chk_flag("async", ST_AE, ael8, 1'b1);
    chk_flag("async", ST_OVF, ovf8, 1'b0);
    chk_flag("async", ST_UDF, udf8, 1'b0);
    chk("async wr_ack", {31'd0, ack8}, 32'd0);
`ifndef FIFO_FWFT_EN
    chk("async rd_valid", {31'd0, rv8}, 32'd0);
    chk("async data_out", 32'(dout8), 32'd0);
`endif
    wr8 = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc8(1, 0, 16'hA5A5);
    chk("post-rst wr count", 32'(cnt8), 32'd1);
    chk("post-rst wr_ack", {31'd0, ack8}, 32'd1);
`ifdef FIFO_FWFT_EN
    chk("post-rst fwft rd_valid", {31'd0, rv8}, 32'd1);
    chk("post-rst fwft data_out", 32'(dout8), 32'hA5A5);
`else
    chk("post-rst rd_valid", {31'd0, rv8}, 32'd0);
`endif
    cyc8(0, 1, 16'h0);
    chk("post-rst rd count", 32'(cnt8), 32'd0);
    chk_flag("post-rst rd", ST_EMPTY, empty8, 1'b1);
`ifdef FIFO_FWFT_EN
    chk("post-rst fwft rd_valid drop", {31'd0, rv8}, 32'd0);
`else
    chk("post-rst rd_valid", {31'd0, rv8}, 32'd1);
    chk("post-rst data_out", 32'(dout8), 32'hA5A5);
`endif

`ifdef FIFO_FWFT_EN
    // Fall-through: word visible without rd_en, then popped
    cyc8(1, 0, 16'hABCD);
    chk("fwft data_out", 32'(dout8), 32'hABCD);
    chk("fwft rd_valid", {31'd0, rv8}, 32'd1);
    chk("fwft count", 32'(cnt8), 32'd1);
    cyc8(0, 0, 16'h0);
    chk("fwft hold data_out", 32'(dout8), 32'hABCD);
    cyc8(0, 1, 16'h0);
    chk_flag("fwft pop", ST_EMPTY, empty8, 1'b1);
    chk("fwft pop rd_valid", {31'd0, rv8}, 32'd0);
`endif

    // Depth-5: prime two words, then continuous write+read across pointer wraps
    for (int k = 0; k < 2; k++) begin
      wr5 = 1'b1; din5 = 16'(16'h100 + k);
      @(posedge clk);
      #1;
    end
    chk("d5 prime count", 32'(cnt5), 32'd2);
    for (int i = 0; i < 20; i++) begin
      wr5 = 1'b1; rd5 = 1'b1; din5 = 16'(16'h102 + i);
      @(posedge clk);
      #1;
      chk($sformatf("d5 c%0d count", i), 32'(cnt5), 32'd2);
`ifdef FIFO_FWFT_EN
      chk($sformatf("d5 c%0d data_out", i), 32'(dout5), 32'(16'h101 + i));
`else
      chk($sformatf("d5 c%0d data_out", i), 32'(dout5), 32'(16'h100 + i));
`endif
      chk($sformatf("d5 c%0d rd_valid", i), {31'd0, rv5}, 32'd1);
      chk($sformatf("d5 c%0d wr_ack", i), {31'd0, ack5}, 32'd1);
      chk_flag($sformatf("d5 c%0d", i), ST_OVF, ovf5, 1'b0);
      chk_flag($sformatf("d5 c%0d", i), ST_UDF, udf5, 1'b0);
      chk_flag($sformatf("d5 c%0d", i), ST_FULL, full5, 1'b0);
      chk_flag($sformatf("d5 c%0d", i), ST_EMPTY, empty5, 1'b0);
      chk_flag($sformatf("d5 c%0d", i), ST_AF, afl5, 1'b0);
      chk_flag($sformatf("d5 c%0d", i), ST_AE, ael5, 1'b0);
    end
    wr5 = 1'b0; rd5 = 1'b0;

    // Threshold corners at count 2, applied combinationally
    af5 = 3'd0; #1; chk_flag("thr af=0", ST_AF, afl5, 1'b1);
    af5 = 3'd6; #1; chk_flag("thr af=6", ST_AF, afl5, 1'b0);
    af5 = 3'd2; #1; chk_flag("thr af=2", ST_AF, afl5, 1'b1);
    af5 = 3'd3; #1; chk_flag("thr af=3", ST_AF, afl5, 1'b0);
    ae5 = 3'd5; #1; chk_flag("thr ae=5", ST_AE, ael5, 1'b1);
    ae5 = 3'd2; #1; chk_flag("thr ae=2", ST_AE, ael5, 1'b1);
    ae5 = 3'd1; #1; chk_flag("thr ae=1", ST_AE, ael5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised successor to the team's single-clock FIFO. Adds:
- arbitrary (non-power-of-two) depth
- run-time programmable almost-full/almost-empty thresholds
- an occupancy count output
- a read-valid strobe
- fully defined simultaneous read/write behaviour

Sits between producer/consumer stages as the general-purpose rate-matching buffer.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of storage entries (>=2, need not be a power of two)
CNT_W, $clog2(FIFO_DEPTH+1), localparam: width of count and threshold buses

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
data_in  input  FIFO_WIDTH  write data
rd_en  input  1  read request
data_out  output  FIFO_WIDTH  read data
rd_valid  output  1  data_out carries a newly read word
af_thresh  input  CNT_W  almost-full threshold (quasi-static)
ae_thresh  input  CNT_W  almost-empty threshold (quasi-static)
count  output  CNT_W  current occupancy 0..FIFO_DEPTH
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almostfull  output  1  count >= af_thresh
almostempty  output  1  count <= ae_thresh
wr_ack  output  1  previous-cycle write accepted
overflow  output  1  previous-cycle write rejected because full
underflow  output  1  previous-cycle read rejected because empty

Behaviour:
- One clock domain (clk); reset asynchronous, active-low (rst_n).
- Reset, including mid-operation:
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0; rd_valid, wr_ack, overflow, underflow = 0.
  - Hence empty = 1, full = 0.
  - Memory contents are not cleared.
- Acceptance is evaluated on pre-edge state:
  - wr_acc = wr_en && !full
  - rd_acc = rd_en && !empty
- Simultaneous requests:
  - When full: read accepted, write rejected; overflow = 1 next cycle, count goes to DEPTH-1.
  - When empty: write accepted, read rejected; underflow = 1 next cycle, count goes to 1.
  - Otherwise both accepted; count unchanged.
- count_next = count + wr_acc - rd_acc. count never exceeds FIFO_DEPTH and never wraps below 0.
- Pointer update: each pointer advances by 1 on its accept and wraps from FIFO_DEPTH-1 to 0. Plain binary rollover is not permitted, so that non-power-of-two depths work.
- Write: mem[wr_ptr] <= data_in on wr_acc.
- Registered status pulses (1-cycle latency, held for one cycle only):
  - wr_ack = wr_acc
  - overflow = wr_en && full
  - underflow = rd_en && empty
- Read, standard mode: on rd_acc, data_out <= mem[rd_ptr] and rd_valid = 1 in the next cycle; otherwise data_out holds its value and rd_valid = 0.
- full, empty, almostfull, almostempty are combinational from the count register and the threshold inputs.
- Threshold corner cases:
  - af_thresh = 0 forces almostfull = 1.
  - af_thresh > FIFO_DEPTH forces almostfull = 0.
  - ae_thresh >= FIFO_DEPTH forces almostempty = 1.
- Thresholds are compared unsigned. Changing a threshold takes effect in the same cycle with no storage.

Optional Feature:
FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever !empty.
  - rd_valid = !empty, combinational.
  - rd_en acts as a pop/acknowledge of the presented word, with the same rd_acc rule.
  - A word written into an empty FIFO appears on data_out the cycle after its write.
  - data_out is don't-care while empty.
- Undefined: standard registered read with 1-cycle latency, as described above.
- Flags, count, overflow and underflow are identical in both modes.

Decomposition:
- shared_pkg additions:
  - default constants FIFO_WIDTH_DEF = 16 and FIFO_DEPTH_DEF = 8
  - a status-flag enum for the bench scoreboard (ST_FULL, ST_EMPTY, ST_AF, ST_AE, ST_OVF, ST_UDF)
- One sub-module, fifo_wrap_ptr: parametrised modulo-FIFO_DEPTH pointer (inc enable, async reset to 0, wrap at DEPTH-1). Instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
1. DEPTH=8, af=6, ae=2, 8 writes 0x0001..0x0008 with no reads:
   - almostfull rises when count=6
   - full=1 at count=8
   - 9th write gives overflow=1, wr_ack=0, count stays 8
2. From full, 8 reads:
   - data_out returns 0x0001..0x0008 in order, each with rd_valid one cycle after rd_en (standard mode)
   - empty=1 afterwards
   - an extra read gives underflow=1 with data_out held at 0x0008
3. Simultaneous wr_en=rd_en=1:
   - when empty: count 0->1, underflow=1, wr_ack=1
   - when full: count 8->7, overflow=1, oldest word read out
4. DEPTH=5, 20 cycles of continuous write+read with count held at 2:
   - pointers wrap 4->0
   - data order preserved, no spurious flags
5. Assert rst_n=0 mid-burst at count=4:
   - count, flags and pulses clear immediately (asynchronously)
   - empty=1
   - the first post-reset write/read returns the new data
6. With FIFO_FWFT_EN:
   - write 0xABCD into an empty FIFO: data_out=0xABCD and rd_valid=1 the next cycle with no rd_en
   - rd_en pops it, giving empty=1
